// File: rtl/mem_tg_csr_pkg.sv
// mem_tg_csr_pkg: register map, control bit positions and status layout for the TG CSR target
package mem_tg_csr_pkg;
  localparam int unsigned OFS_DFH     = 'h00;
  localparam int unsigned OFS_GUID_L  = 'h08;
  localparam int unsigned OFS_GUID_H  = 'h10;
  localparam int unsigned OFS_SCRATCH = 'h18;
  localparam int unsigned OFS_TG_CTRL = 'h20;
  localparam int unsigned OFS_TG_STAT = 'h28;
  localparam int unsigned OFS_LOOP    = 'h30;
  localparam int unsigned OFS_CLK     = 'h38;
  localparam int unsigned OFS_ERR     = 'h40;
  localparam int unsigned START_LSB = 0;
  localparam int unsigned CLR_BIT   = 32;
  localparam int unsigned STAT_W    = 4;
  localparam logic [3:0]  DFH_TYPE = 4'h3;
  localparam logic [23:0] DFH_NEXT = 24'h001000;
  localparam logic [11:0] DFH_ID   = 12'h010;
  localparam logic [63:0] DFH_DEFAULT = {DFH_TYPE, 20'h0, DFH_NEXT, 4'h0, DFH_ID};
  typedef struct packed {
    logic rsvd;
    logic fail;
    logic pass;
    logic active;
  } tg_stat_nib_t;
  function automatic tg_stat_nib_t stat_nib(input logic a, input logic p, input logic f);
    return '{rsvd: 1'b0, fail: f, pass: p, active: a};
  endfunction
endpackage

// File: rtl/mem_tg_sat_counter.sv
// mem_tg_sat_counter: saturating up-counter with clear priority over increment
module mem_tg_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst || clr) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
  end
endmodule

// File: rtl/mem_tg_csr_slave.sv
// mem_tg_csr_slave: AVMM CSR target driving TG start/loop controls and saturating counters
module mem_tg_csr_slave
  import mem_tg_csr_pkg::*;
#(
  parameter int            MM_ADDR_WIDTH = 18,
  parameter int            MM_DATA_WIDTH = 64,
  parameter int            NUM_TG        = 4,
  parameter logic [63:0]   DFH_VALUE     = DFH_DEFAULT,
  parameter logic [127:0]  GUID          = 128'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     avmm_write,
  input  logic                     avmm_read,
  input  logic [MM_ADDR_WIDTH-1:0] avmm_address,
  input  logic [MM_DATA_WIDTH-1:0] avmm_writedata,
  input  logic [7:0]               avmm_byteenable,
  output logic                     avmm_waitrequest,
  output logic [MM_DATA_WIDTH-1:0] avmm_readdata,
  output logic                     avmm_readdatavalid,
  output logic                     avmm_writeresponsevalid,
  output logic [NUM_TG-1:0]        tg_start,
  output logic [31:0]              tg_loop_count,
  input  logic [NUM_TG-1:0]        tg_active,
  input  logic [NUM_TG-1:0]        tg_pass,
  input  logic [NUM_TG-1:0]        tg_fail,
  input  logic [NUM_TG-1:0]        tg_err_pulse
);
  localparam int WW = MM_ADDR_WIDTH - 3;
  if (MM_DATA_WIDTH != 64 || NUM_TG < 1 || NUM_TG > 8) begin : g_bad_cfg
    $error("mem_tg_csr_slave: MM_DATA_WIDTH must be 64 and NUM_TG 1..8");
  end
  function automatic logic [WW-1:0] wi(input int unsigned ofs);
    return WW'(ofs >> 3);
  endfunction
  logic              wait_q, rdv_q, wrv_q, acc, acc_w, acc_r, ctrl_w, clr_cnt;
  logic [WW-1:0]     w;
  logic [63:0]       scratch, rdata, rd, stat, clk_cnt;
  logic [31:0]       loop_q;
  logic [31:0]       err_cnt [NUM_TG];
  logic [NUM_TG-1:0] start_now, start_q;
  logic              unused_addr;
  assign unused_addr = ^avmm_address[2:0];
  assign w       = avmm_address[MM_ADDR_WIDTH-1:3];
  assign acc     = !wait_q && !rst;
  assign acc_w   = acc && avmm_write;
  assign acc_r   = acc && avmm_read && !avmm_write;
  assign ctrl_w  = acc_w && w == wi(OFS_TG_CTRL);
  // starts into an already-busy channel are swallowed here so they also don't zero CLK_COUNT
  assign start_now = ctrl_w && avmm_byteenable[START_LSB/8] ? avmm_writedata[START_LSB +: NUM_TG] & ~tg_active : '0;
  assign clr_cnt   = ctrl_w && avmm_byteenable[CLR_BIT/8] && avmm_writedata[CLR_BIT];
  always_comb begin
    stat = '0;
    for (int i = 0; i < NUM_TG; i++) stat[STAT_W*i +: STAT_W] = stat_nib(tg_active[i], tg_pass[i], tg_fail[i]);
  end
  always_comb begin
    rd = w == wi(OFS_DFH)     ? DFH_VALUE :
         w == wi(OFS_GUID_L)  ? GUID[63:0] :
         w == wi(OFS_GUID_H)  ? GUID[127:64] :
         w == wi(OFS_SCRATCH) ? scratch :
         w == wi(OFS_TG_STAT) ? stat :
         w == wi(OFS_LOOP)    ? {32'h0, loop_q} :
         w == wi(OFS_CLK)     ? clk_cnt : '0;
    for (int i = 0; i < NUM_TG; i++) if (w == wi(OFS_ERR + 8*i)) rd = {32'h0, err_cnt[i]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q  <= 1'b1;
      rdv_q   <= 1'b0;
      wrv_q   <= 1'b0;
      rdata   <= '0;
      start_q <= '0;
      scratch <= '0;
      loop_q  <= 32'd1;
    end else begin
      wait_q  <= 1'b0;
      rdv_q   <= acc_r;
      wrv_q   <= acc_w;
      start_q <= start_now;
      if (acc_r) rdata <= rd;
      for (int i = 0; i < 8; i++)
        if (acc_w && w == wi(OFS_SCRATCH) && avmm_byteenable[i]) scratch[8*i +: 8] <= avmm_writedata[8*i +: 8];
      for (int i = 0; i < 4; i++)
        if (acc_w && w == wi(OFS_LOOP) && avmm_byteenable[i]) loop_q[8*i +: 8] <= avmm_writedata[8*i +: 8];
    end
  end
  always @(posedge clk)
    if (acc) assert (!(avmm_read && avmm_write)) else $warning("mem_tg_csr_slave: read and write together, read dropped");
  mem_tg_sat_counter #(.WIDTH(64)) u_clk_cnt (
    .clk(clk), .rst(rst), .clr(clr_cnt || (|start_now)), .inc(|tg_active), .count(clk_cnt)
  );
  for (genvar n = 0; n < NUM_TG; n++) begin : g_err
    mem_tg_sat_counter #(.WIDTH(32)) u_err_cnt (
      .clk(clk), .rst(rst), .clr(clr_cnt), .inc(tg_err_pulse[n]), .count(err_cnt[n])
    );
  end
  // responses still in flight when reset arrives are suppressed at the port
  assign avmm_waitrequest        = wait_q;
  assign avmm_readdata           = rdata;
  assign avmm_readdatavalid      = rdv_q && !rst;
  assign avmm_writeresponsevalid = wrv_q && !rst;
  assign tg_start                = start_q & {NUM_TG{!rst}};
  assign tg_loop_count           = loop_q;
endmodule

// File: tb/tb_mem_tg_csr_slave.sv
// tb_mem_tg_csr_slave: vector table, randomized model checks and corner sequences for mem_tg_csr_slave
module tb_mem_tg_csr_slave;
  localparam logic [127:0] GUID_P = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [63:0]  DFH_P  = 64'h3000_0000_1000_0010;
  logic        clk = 1'b0;
  logic        rst;
  logic        avmm_write, avmm_read;
  logic [17:0] avmm_address;
  logic [63:0] avmm_writedata;
  logic [7:0]  avmm_byteenable;
  logic        avmm_waitrequest, avmm_readdatavalid, avmm_writeresponsevalid;
  logic [63:0] avmm_readdata;
  logic [3:0]  tg_start, tg_active, tg_pass, tg_fail, tg_err_pulse;
  logic [31:0] tg_loop_count;
  logic        sc_clr, sc_inc;
  logic [3:0]  sc_cnt;
  int          tests = 0, fails = 0;
  logic [3:0]  st_snap;

  always #5 clk = ~clk;

  mem_tg_csr_slave #(.MM_ADDR_WIDTH(18), .MM_DATA_WIDTH(64), .NUM_TG(4), .DFH_VALUE(DFH_P), .GUID(GUID_P)) dut (
    .clk(clk), .rst(rst), .avmm_write(avmm_write), .avmm_read(avmm_read),
    .avmm_address(avmm_address), .avmm_writedata(avmm_writedata), .avmm_byteenable(avmm_byteenable),
    .avmm_waitrequest(avmm_waitrequest), .avmm_readdata(avmm_readdata),
    .avmm_readdatavalid(avmm_readdatavalid), .avmm_writeresponsevalid(avmm_writeresponsevalid),
    .tg_start(tg_start), .tg_loop_count(tg_loop_count), .tg_active(tg_active),
    .tg_pass(tg_pass), .tg_fail(tg_fail), .tg_err_pulse(tg_err_pulse)
  );

  mem_tg_sat_counter #(.WIDTH(4)) u_sc (.clk(clk), .rst(rst), .clr(sc_clr), .inc(sc_inc), .count(sc_cnt));

  typedef struct {
    bit          wr;
    logic [17:0] a;
    logic [63:0] d;
    logic [7:0]  be;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [17:0] a, input logic [63:0] d, input logic [7:0] be);
    chk("wr_waitrequest", avmm_waitrequest, 0);
    avmm_write = 1; avmm_address = a; avmm_writedata = d; avmm_byteenable = be;
    @(posedge clk);
    @(negedge clk);
    avmm_write = 0;
    chk("wr_response", avmm_writeresponsevalid, 1);
    st_snap = tg_start;
  endtask

  task automatic bus_rd(input logic [17:0] a, output logic [63:0] d);
    chk("rd_waitrequest", avmm_waitrequest, 0);
    avmm_read = 1; avmm_address = a;
    @(posedge clk);
    @(negedge clk);
    avmm_read = 0;
    chk("rd_valid", avmm_readdatavalid, 1);
    d = avmm_readdata;
  endtask

  initial begin
    #600000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] d, scr, exp;
    logic [31:0] lp;
    int nrdv;
    rst = 1; avmm_write = 0; avmm_read = 0; avmm_address = '0; avmm_writedata = '0; avmm_byteenable = '0;
    tg_active = 0; tg_pass = 0; tg_fail = 0; tg_err_pulse = 0; sc_clr = 0; sc_inc = 0;
    repeat (3) @(negedge clk);
    chk("rst_wait", avmm_waitrequest, 1);
    chk("rst_rdata", avmm_readdata, 0);
    chk("rst_rdv", avmm_readdatavalid, 0);
    chk("rst_wrv", avmm_writeresponsevalid, 0);
    chk("rst_start", tg_start, 0);
    chk("rst_loop", tg_loop_count, 1);
    rst = 0;
    chk("wait_after_rst", avmm_waitrequest, 1);
    @(negedge clk);
    chk("wait_ready", avmm_waitrequest, 0);

    tbl.push_back('{0, 18'h00, 64'h0, 8'h00, DFH_P});
    tbl.push_back('{0, 18'h08, 64'h0, 8'h00, GUID_P[63:0]});
    tbl.push_back('{0, 18'h10, 64'h0, 8'h00, GUID_P[127:64]});
    tbl.push_back('{0, 18'h18, 64'h0, 8'h00, 64'h0});
    tbl.push_back('{1, 18'h18, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 64'h0});
    tbl.push_back('{0, 18'h18, 64'h0, 8'h00, 64'h0000_0000_CAFE_F00D});
    tbl.push_back('{1, 18'h18, 64'h1122_3344_5566_7788, 8'hA0, 64'h0});
    tbl.push_back('{0, 18'h18, 64'h0, 8'h00, 64'h1100_3300_CAFE_F00D});
    tbl.push_back('{1, 18'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0});
    tbl.push_back('{0, 18'h1F, 64'h0, 8'h00, 64'h1100_3300_CAFE_F00D});
    tbl.push_back('{0, 18'h30, 64'h0, 8'h00, 64'h1});
    tbl.push_back('{1, 18'h30, 64'hFFFF_FFFF_1234_5678, 8'hFF, 64'h0});
    tbl.push_back('{0, 18'h30, 64'h0, 8'h00, 64'h0000_0000_1234_5678});
    tbl.push_back('{1, 18'h00, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0});
    tbl.push_back('{0, 18'h00, 64'h0, 8'h00, DFH_P});
    tbl.push_back('{0, 18'h20, 64'h0, 8'h00, 64'h0});
    tbl.push_back('{0, 18'h28, 64'h0, 8'h00, 64'h0});
    tbl.push_back('{0, 18'h60, 64'h0, 8'h00, 64'h0});
    tbl.push_back('{1, 18'h60, 64'h1234, 8'hFF, 64'h0});
    tbl.push_back('{0, 18'h60, 64'h0, 8'h00, 64'h0});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) bus_wr(tbl[i].a, tbl[i].d, tbl[i].be);
      else begin
        bus_rd(tbl[i].a, d);
        chk($sformatf("tbl_%0d_rd_%h", i, tbl[i].a), d, tbl[i].exp);
      end
    end
    chk("loop_port", tg_loop_count, 32'h1234_5678);

    scr = 64'h1100_3300_CAFE_F00D;
    lp  = 32'h1234_5678;
    for (int i = 0; i < 300; i++) begin
      int op;
      logic [63:0] rv;
      logic [7:0]  be;
      op = $urandom_range(0, 3);
      rv = {$urandom, $urandom};
      be = 8'($urandom);
      if (op == 0) begin
        bus_wr(18'h18, rv, be);
        for (int b = 0; b < 8; b++) if (be[b]) scr[8*b +: 8] = rv[8*b +: 8];
      end else if (op == 1) begin
        bus_wr(18'h30, rv, be);
        for (int b = 0; b < 4; b++) if (be[b]) lp[8*b +: 8] = rv[8*b +: 8];
      end else if (op == 2) begin
        bus_rd(18'h18, d);
        chk("rand_scratch", d, scr);
        bus_rd(18'h30, d);
        chk("rand_loop", d, {32'h0, lp});
      end else begin
        tg_active = 4'($urandom); tg_pass = 4'($urandom); tg_fail = 4'($urandom);
        exp = 0;
        for (int n = 0; n < 4; n++) exp = exp + (64'(tg_active[n]) + 2 * 64'(tg_pass[n]) + 4 * 64'(tg_fail[n])) * (64'd1 << (4 * n));
        bus_rd(18'h28, d);
        chk("rand_stat", d, exp);
      end
    end
    tg_active = 0; tg_pass = 0; tg_fail = 0;

    bus_wr(18'h20, 64'h5, 8'h01);
    chk("start_0101", st_snap, 4'b0101);
    @(negedge clk);
    chk("start_one_cycle", tg_start, 0);
    tg_active = 4'b0001;
    bus_wr(18'h20, 64'h5, 8'h01);
    chk("start_masked", st_snap, 4'b0100);
    tg_active = 0;
    bus_wr(18'h20, 64'hF, 8'h02);
    chk("start_no_be0", st_snap, 4'b0000);
    bus_rd(18'h20, d);
    chk("ctrl_reads_0", d, 0);

    bus_wr(18'h20, 64'h1_0000_0000, 8'h10);
    bus_wr(18'h20, 64'h2, 8'h01);
    tg_active = 4'b0010;
    repeat (100) @(negedge clk);
    tg_active = 0;
    bus_rd(18'h38, d);
    chk("clk_count_100", d, 100);
    bus_rd(18'h38, d);
    chk("clk_count_hold", d, 100);
    tg_active = 4'b0010;
    bus_wr(18'h20, 64'h4, 8'h01);
    tg_active = 0;
    chk("start_while_other_busy", st_snap, 4'b0100);
    bus_rd(18'h38, d);
    chk("clk_zero_wins", d, 0);

    sc_clr = 1;
    @(negedge clk);
    sc_clr = 0; sc_inc = 1;
    repeat (20) @(negedge clk);
    chk("sat_allones", sc_cnt, 4'hF);
    @(negedge clk);
    chk("sat_hold", sc_cnt, 4'hF);
    sc_clr = 1;
    @(negedge clk);
    chk("sat_clr_wins", sc_cnt, 0);
    sc_clr = 0;
    repeat (3) @(negedge clk);
    sc_inc = 0;
    chk("sat_count3", sc_cnt, 3);

    bus_wr(18'h20, 64'h1_0000_0000, 8'h10);
    tg_err_pulse = 4'b0100;
    @(negedge clk);
    tg_err_pulse = 0;
    tg_err_pulse = 4'b0100;
    bus_wr(18'h20, 64'h1_0000_0000, 8'h10);
    tg_err_pulse = 0;
    for (int k = 0; k < 2; k++) begin
      tg_err_pulse = 4'b0100;
      @(negedge clk);
      tg_err_pulse = 0;
      @(negedge clk);
    end
    bus_rd(18'h50, d);
    chk("err2_after_clear", d, 2);
    tg_err_pulse = 4'b0100;
    bus_rd(18'h50, d);
    tg_err_pulse = 0;
    chk("err2_pre_increment", d, 2);
    bus_rd(18'h50, d);
    chk("err2_post_increment", d, 3);
    bus_rd(18'h40, d);
    chk("err0_zero", d, 0);
    bus_rd(18'h58, d);
    chk("err3_zero", d, 0);
    bus_rd(18'h60, d);
    chk("err_past_end", d, 0);

    bus_wr(18'h18, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF);
    nrdv = 0;
    avmm_read = 1; avmm_address = 18'h18;
    @(posedge clk);
    @(negedge clk);
    if (avmm_readdatavalid) nrdv++;
    chk("b2b_data", avmm_readdata, 64'hA5A5_5A5A_0F0F_F0F0);
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    if (avmm_readdatavalid) nrdv++;
    chk("rst_mid_start", tg_start, 0);
    @(negedge clk);
    if (avmm_readdatavalid) nrdv++;
    avmm_read = 0;
    repeat (3) begin
      @(negedge clk);
      if (avmm_readdatavalid) nrdv++;
    end
    rst = 0;
    if (avmm_readdatavalid) nrdv++;
    chk("rst_mid_wait", avmm_waitrequest, 1);
    @(negedge clk);
    if (avmm_readdatavalid) nrdv++;
    chk("rst_mid_rdv_count", 64'(nrdv), 1);
    bus_rd(18'h18, d);
    chk("rst_mid_scratch", d, 0);
    bus_rd(18'h30, d);
    chk("rst_mid_loop", d, 1);

    avmm_write = 1; avmm_read = 1; avmm_address = 18'h18;
    avmm_writedata = 64'h0123_4567_89AB_CDEF; avmm_byteenable = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    avmm_write = 0; avmm_read = 0;
    chk("rw_no_rdv", avmm_readdatavalid, 0);
    chk("rw_wrv", avmm_writeresponsevalid, 1);
    bus_rd(18'h18, d);
    chk("rw_write_applied", d, 64'h0123_4567_89AB_CDEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
